// File: rtl/pulpemu_apb_pkg.sv
// Shared types and constants for the pulpemu APB 1-to-N demultiplexer.
package pulpemu_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } apb_demux_state_e;

  localparam logic [63:0] APB_ERR_RDATA = '0;
  localparam int unsigned ERR_CNT_W     = 8;

endpackage

// File: rtl/pulpemu_apb_demux_fsm.sv
// Transfer tracking for the APB demux: state, latched slave index, error bookkeeping.
// Optional access timeout enabled by PULPEMU_APB_DEMUX_TIMEOUT_EN.
module pulpemu_apb_demux_fsm
  import pulpemu_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [SEL_WIDTH-1:0]  i_idx,
  input  logic                  i_decerr,
  input  logic                  i_rsp_ready,
  output apb_demux_state_e      o_state,
  output logic [SEL_WIDTH-1:0]  o_sel_q,
  output logic                  o_decerr_q,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);

  localparam int unsigned TO_W = 16;

  apb_demux_state_e      r_state;
  apb_demux_state_e      w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_sel_q;
  logic                  r_decerr_q;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  w_err_evt;
  logic                  w_to_inc;
  logic [TO_W-1:0]       r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; a local error is either a decode error or an expired access timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_err_evt   = 1'b0;
    w_to_inc    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_psel) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!i_psel) begin
          w_state_nxt = IDLE;
        end else if (i_penable) begin
          if (r_decerr_q) begin
            w_err_evt   = 1'b1;
            w_state_nxt = IDLE;
          end else if (i_rsp_ready) begin
            w_state_nxt = IDLE;
`ifdef PULPEMU_APB_DEMUX_TIMEOUT_EN
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_err_evt   = 1'b1;
            w_state_nxt = ERR;
          end else begin
            w_to_inc    = 1'b1;
`endif
          end
        end
      end
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q    <= '0;
      r_decerr_q <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (r_state == IDLE && i_psel) begin
        r_sel_q    <= i_idx;
        r_decerr_q <= i_decerr;
      end
      if (w_err_evt) begin
        r_err_addr <= i_paddr;
        if (r_err_cnt != {ERR_CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
      if (w_state_nxt == IDLE) r_to_cnt <= '0;
      else if (w_to_inc)       r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign o_state    = r_state;
  assign o_sel_q    = r_sel_q;
  assign o_decerr_q = r_decerr_q;
  assign o_err_addr = r_err_addr;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/pulpemu_apb_demux_n.sv
// APB3 1-to-N demux: address decode, request broadcast and selected-slave response mux.
// Optional access timeout enabled by PULPEMU_APB_DEMUX_TIMEOUT_EN.
module pulpemu_apb_demux_n
  import pulpemu_apb_pkg::*;
#(
  parameter int unsigned NB_SLAVES      = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_LSB        = 14,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_WIDTH-1:0]           s_paddr,
  input  logic                            s_psel,
  input  logic                            s_penable,
  input  logic                            s_pwrite,
  input  logic [DATA_WIDTH-1:0]           s_pwdata,
  output logic [DATA_WIDTH-1:0]           s_prdata,
  output logic                            s_pready,
  output logic                            s_pslverr,
  output logic [NB_SLAVES*ADDR_WIDTH-1:0] m_paddr,
  output logic [NB_SLAVES-1:0]            m_psel,
  output logic [NB_SLAVES-1:0]            m_penable,
  output logic [NB_SLAVES-1:0]            m_pwrite,
  output logic [NB_SLAVES*DATA_WIDTH-1:0] m_pwdata,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [NB_SLAVES-1:0]            m_pready,
  input  logic [NB_SLAVES-1:0]            m_pslverr,
  output logic [ADDR_WIDTH-1:0]           err_addr,
  output logic [ERR_CNT_W-1:0]            err_cnt
);

  logic [SEL_WIDTH-1:0]  w_idx;
  logic                  w_decerr;
  apb_demux_state_e      w_state;
  logic [SEL_WIDTH-1:0]  w_sel_q;
  logic                  w_decerr_q;
  logic [NB_SLAVES-1:0]  w_psel;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_rsp_ready;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  assign w_idx    = s_paddr[SEL_LSB +: SEL_WIDTH];
  assign w_decerr = ({1'b0, w_idx} >= (SEL_WIDTH + 1)'(NB_SLAVES));

  pulpemu_apb_demux_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .SEL_WIDTH     (SEL_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_psel     (s_psel),
    .i_penable  (s_penable),
    .i_paddr    (s_paddr),
    .i_idx      (w_idx),
    .i_decerr   (w_decerr),
    .i_rsp_ready(w_rsp_ready),
    .o_state    (w_state),
    .o_sel_q    (w_sel_q),
    .o_decerr_q (w_decerr_q),
    .o_err_addr (err_addr),
    .o_err_cnt  (err_cnt)
  );

  // Select is suppressed in ERR so a timed-out slave observes the abort.
  always_comb begin
    w_psel = '0;
    for (int i = 0; i < int'(NB_SLAVES); i++) begin
      w_psel[i] = s_psel && !w_decerr && (w_idx == SEL_WIDTH'(i)) && (w_state != ERR);
    end
  end

  assign m_psel    = w_psel;
  assign m_paddr   = {NB_SLAVES{s_paddr}};
  assign m_penable = {NB_SLAVES{s_penable}};
  assign m_pwrite  = {NB_SLAVES{s_pwrite}};
  assign m_pwdata  = {NB_SLAVES{s_pwdata}};

  // Only the slave latched at setup can answer; other slaves' pready is ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(NB_SLAVES); i++) begin
      if (w_sel_q == SEL_WIDTH'(i)) begin
        w_sel_ready = m_pready[i];
        w_sel_err   = m_pslverr[i];
        w_sel_data  = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rsp_ready = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_data  = '0;
    unique case (w_state)
      ACCESS: begin
        if (s_penable) begin
          if (w_decerr_q) begin
            w_rsp_ready = 1'b1;
            w_rsp_err   = 1'b1;
            w_rsp_data  = DATA_WIDTH'(APB_ERR_RDATA);
          end else begin
            w_rsp_ready = w_sel_ready;
            w_rsp_err   = w_sel_err;
            w_rsp_data  = w_sel_data;
          end
        end
      end
      ERR: begin
        w_rsp_ready = 1'b1;
        w_rsp_err   = 1'b1;
        w_rsp_data  = DATA_WIDTH'(APB_ERR_RDATA);
      end
      default: ;
    endcase
  end

  assign s_pready  = w_rsp_ready;
  assign s_pslverr = w_rsp_err;
  assign s_prdata  = w_rsp_data;

endmodule

// File: tb/tb_pulpemu_apb_demux_n.sv
// Scoreboard bench for pulpemu_apb_demux_n: directed transfers with a small wait-state slave model.
module tb_pulpemu_apb_demux_n;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     s_paddr = '0;
  logic              s_psel = 1'b0;
  logic              s_penable = 1'b0;
  logic              s_pwrite = 1'b0;
  logic [DW-1:0]     s_pwdata = '0;
  logic [DW-1:0]     s_prdata;
  logic              s_pready;
  logic              s_pslverr;
  logic [NB*AW-1:0]  m_paddr;
  logic [NB-1:0]     m_psel;
  logic [NB-1:0]     m_penable;
  logic [NB-1:0]     m_pwrite;
  logic [NB*DW-1:0]  m_pwdata;
  logic [NB*DW-1:0]  m_prdata;
  logic [NB-1:0]     m_pready;
  logic [NB-1:0]     m_pslverr;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  pulpemu_apb_demux_n #(
    .NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_LSB(14), .SEL_WIDTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic [NB-1:0] psel;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   completions = 0;

  // Slave model: ready after waits[i] enable cycles, or stuck ready regardless of select.
  int            waits [NB];
  logic          stuck [NB];
  logic          sl_err[NB];
  logic [DW-1:0] sl_data[NB];
  int            wcnt  [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      m_pready[i]             = stuck[i] | (m_psel[i] & m_penable[i] & (wcnt[i] == waits[i]));
      m_pslverr[i]            = sl_err[i];
      m_prdata[i*DW +: DW]    = sl_data[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (m_psel[i] && m_penable[i] && !m_pready[i]) wcnt[i] <= wcnt[i] + 1;
      else                                           wcnt[i] <= 0;
    end
  end

  function automatic exp_t mk(input logic [DW-1:0] d, input logic e, input logic [NB-1:0] p);
    exp_t r;
    r.rdata = d; r.slverr = e; r.psel = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every completed transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && s_psel && s_penable && s_pready) begin
      exp_t e;
      completions++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp rdata=0x%0h slverr=%0b", s_prdata, s_pslverr);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", 64'(s_prdata), 64'(e.rdata));
        chk("rsp_slverr", 64'(s_pslverr), 64'(e.slverr));
        chk("rsp_m_psel", 64'(m_psel), 64'(e.psel));
      end
    end
  end

  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                      input exp_t e, input int exp_waits, input string nm);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(posedge clk); #1;
    s_paddr = a; s_pwrite = wr; s_pwdata = wd; s_psel = 1'b1; s_penable = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    s_penable = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (s_pready) got = 1'b1;
      else          n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_no_ready actual=none required=ready within 100 cycles", nm);
    end else begin
      chk({nm, "_waits"}, 64'(n), 64'(exp_waits));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_psel = 1'b0;
    s_penable = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < NB; i++) begin
      waits[i] = 0; stuck[i] = 1'b0; sl_err[i] = 1'b0; sl_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 64'(s_pready), 64'h0);
    chk("rst_pslverr", 64'(s_pslverr), 64'h0);
    chk("rst_prdata", 64'(s_prdata), 64'h0);
    chk("rst_err_cnt", 64'(err_cnt), 64'h0);
    chk("rst_err_addr", 64'(err_addr), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write to slave 1 with two wait states.
    waits[1] = 2; sl_data[1] = 32'h1111_1111;
    c0 = completions;
    xfer(32'h5101_4008, 1'b1, 32'hA5A5_A5A5, mk(32'h1111_1111, 1'b0, 3'b010), 2, "t1");
    chk("t1_m_pwdata1", 64'(m_pwdata[DW +: DW]), 64'hA5A5_A5A5);
    chk("t1_m_paddr2", 64'(m_paddr[2*AW +: AW]), 64'h5101_4008);
    chk("t1_m_pwrite", 64'(m_pwrite), 64'h7);
    idle();
    chk("t1_one_ready", 64'(completions - c0), 64'd1);
    chk("t1_err_cnt", 64'(err_cnt), 64'd0);

    // Read slave 0 while slave 2 holds pready high.
    waits[0] = 1; sl_data[0] = 32'h1234_5678; stuck[2] = 1'b1; sl_data[2] = 32'hDEAD_BEEF;
    c0 = completions;
    xfer(32'h5101_0000, 1'b0, '0, mk(32'h1234_5678, 1'b0, 3'b001), 1, "t2");
    idle();
    chk("t2_one_ready", 64'(completions - c0), 64'd1);
    stuck[2] = 1'b0;

    // Decode error on index 3.
    xfer(32'h5101_C000, 1'b0, '0, mk(32'h0, 1'b1, 3'b000), 0, "t3");
    idle();
    chk("t3_err_addr", 64'(err_addr), 64'h5101_C000);
    chk("t3_err_cnt", 64'(err_cnt), 64'd1);

    // Back-to-back: write slave 2, then read slave 0 which reports its own error.
    waits[2] = 0; sl_err[0] = 1'b1;
    c0 = completions;
    xfer(32'h5101_8000, 1'b1, 32'hCAFE_F00D, mk(32'hDEAD_BEEF, 1'b0, 3'b100), 0, "t4a");
    xfer(32'h5101_0004, 1'b0, '0, mk(32'h1234_5678, 1'b1, 3'b001), 1, "t4b");
    idle();
    chk("t4_two_ready", 64'(completions - c0), 64'd2);
    chk("t4_err_cnt", 64'(err_cnt), 64'd1);
    sl_err[0] = 1'b0;

    // Select dropped after setup: no response and no error counted.
    @(posedge clk); #1;
    s_paddr = 32'h5101_C000; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1;
    s_psel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("viol_err_cnt", 64'(err_cnt), 64'd1);

    // Decode-error burst up to saturation.
    for (int k = 1; k <= 253; k++)
      xfer(32'h5101_C000 | 32'(k << 2), 1'b0, '0, mk(32'h0, 1'b1, 3'b000), 0, "t5");
    idle();
    chk("t5_err_cnt_254", 64'(err_cnt), 64'd254);
    for (int k = 254; k <= 300; k++)
      xfer(32'h5101_C000 | 32'(k << 2), 1'b0, '0, mk(32'h0, 1'b1, 3'b000), 0, "t5");
    idle();
    chk("t5_err_cnt_sat", 64'(err_cnt), 64'd255);
    chk("t5_err_addr", 64'(err_addr), 64'h5101_C4B0);

    // Reset while slave 1 is presenting a response.
    waits[1] = 0; sl_data[1] = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    s_paddr = 32'h5101_4000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    #2;
    chk("rst_mid_pre_ready", 64'(s_pready), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_pready", 64'(s_pready), 64'h0);
    chk("rst_mid_pslverr", 64'(s_pslverr), 64'h0);
    chk("rst_mid_prdata", 64'(s_prdata), 64'h0);
    chk("rst_mid_err_cnt", 64'(err_cnt), 64'h0);
    chk("rst_mid_err_addr", 64'(err_addr), 64'h0);
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(32'h5101_0000, 1'b0, '0, mk(32'h1234_5678, 1'b0, 3'b001), 1, "post_rst");
    idle();

`ifdef PULPEMU_APB_DEMUX_TIMEOUT_EN
    // Slave 1 never ready: forced error after 16 enable cycles.
    waits[1] = 100000;
    xfer(32'h5101_4000, 1'b0, '0, mk(32'h0, 1'b1, 3'b000), 16, "t6");
    idle();
    chk("t6_err_cnt", 64'(err_cnt), 64'd1);
    chk("t6_err_addr", 64'(err_addr), 64'h5101_4000);
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
